// File: rtl/bus_split_arbiter.sv
// Two-master round-robin bus arbiter and transfer sequencer with ERROR/RETRY/SPLIT
// handling and a ready-timeout abort. All outputs are registered.
module bus_split_arbiter #(
   parameter int TIMEOUT_CYC = 16,
   parameter int MAX_RETRY   = 3,
   parameter int CNT_W       = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       busreq_1,
   input  logic       busreq_2,
   input  logic       read_write_1,
   input  logic       read_write_2,
   input  logic       ready,
   input  logic [1:0] response,
   input  logic [1:0] split,
   output logic       grant_1,
   output logic       grant_2,
   output logic       owner,
   output logic       read_write,
   output logic       addr_phase,
   output logic       data_phase,
   output logic       done,
   output logic       error,
   output logic [1:0] split_mask
);

   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;
   localparam logic [1:0] RESP_RETRY = 2'b10;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, TURN} state_t;

   state_t           state, state_n;
   logic             grant_1_n, grant_2_n, owner_n, read_write_n;
   logic             addr_phase_n, data_phase_n, done_n, error_n;
   logic [1:0]       split_mask_n, split_set;
   logic             last_srv, last_srv_n;
   logic [RTY_W-1:0] retry_cnt, retry_cnt_n;
   logic [CNT_W-1:0] to_cnt, to_cnt_n;
   logic [1:0]       eligible;
   logic             winner;
   logic             xfer_end;

   assign eligible = {busreq_2, busreq_1} & ~split_mask;
   // On a tie the master not served last wins; otherwise the lone eligible one.
   assign winner   = (eligible == 2'b11) ? ~last_srv : eligible[1];

   always_comb begin
      state_n      = state;
      grant_1_n    = grant_1;
      grant_2_n    = grant_2;
      owner_n      = owner;
      read_write_n = read_write;
      addr_phase_n = 1'b0;
      data_phase_n = 1'b0;
      done_n       = 1'b0;
      error_n      = 1'b0;
      last_srv_n   = last_srv;
      retry_cnt_n  = retry_cnt;
      to_cnt_n     = to_cnt;
      split_set    = '0;
      xfer_end     = 1'b0;

      case (state)
         IDLE: begin
            grant_1_n = 1'b0;
            grant_2_n = 1'b0;
            if (|eligible) begin
               state_n      = ADDR;
               grant_1_n    = ~winner;
               grant_2_n    = winner;
               owner_n      = winner;
               read_write_n = winner ? read_write_2 : read_write_1;
               addr_phase_n = 1'b1;
               retry_cnt_n  = '0;
            end
         end

         ADDR: begin
            state_n      = DATA;
            data_phase_n = 1'b1;
            to_cnt_n     = '0;
         end

         DATA: begin
            data_phase_n = 1'b1;
            if (!ready) begin
               to_cnt_n = to_cnt + CNT_W'(1);
               if (to_cnt_n == CNT_W'(TIMEOUT_CYC)) begin
                  error_n  = 1'b1;
                  xfer_end = 1'b1;
               end
            end else begin
               case (response)
                  RESP_OKAY: begin
                     done_n      = 1'b1;
                     retry_cnt_n = '0;
                     xfer_end    = 1'b1;
                  end
                  RESP_ERROR: begin
                     error_n  = 1'b1;
                     xfer_end = 1'b1;
                  end
                  RESP_RETRY: begin
                     if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                        // Re-run the address phase for the same owner; grant stays up.
                        retry_cnt_n  = retry_cnt + RTY_W'(1);
                        state_n      = ADDR;
                        addr_phase_n = 1'b1;
                        data_phase_n = 1'b0;
                     end else begin
                        error_n  = 1'b1;
                        xfer_end = 1'b1;
                     end
                  end
                  default: begin
                     split_set[owner] = 1'b1;
                     xfer_end         = 1'b1;
                  end
               endcase
            end
         end

         TURN: begin
            state_n   = IDLE;
            grant_1_n = 1'b0;
            grant_2_n = 1'b0;
         end

         default: state_n = IDLE;
      endcase

      if (xfer_end) begin
         state_n      = TURN;
         grant_1_n    = 1'b0;
         grant_2_n    = 1'b0;
         data_phase_n = 1'b0;
         last_srv_n   = owner;
      end

      // A release pulse wins over a park request for the same master.
      split_mask_n = (split_mask | split_set) & ~split;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         grant_1    <= 1'b0;
         grant_2    <= 1'b0;
         owner      <= 1'b0;
         read_write <= 1'b0;
         addr_phase <= 1'b0;
         data_phase <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         split_mask <= '0;
         last_srv   <= 1'b1;
         retry_cnt  <= '0;
         to_cnt     <= '0;
      end else begin
         state      <= state_n;
         grant_1    <= grant_1_n;
         grant_2    <= grant_2_n;
         owner      <= owner_n;
         read_write <= read_write_n;
         addr_phase <= addr_phase_n;
         data_phase <= data_phase_n;
         done       <= done_n;
         error      <= error_n;
         split_mask <= split_mask_n;
         last_srv   <= last_srv_n;
         retry_cnt  <= retry_cnt_n;
         to_cnt     <= to_cnt_n;
      end
   end

endmodule
